multicycle_ctrl: RTL and testbench

Multicycle control unit that drives the register file's port set (read addresses, write address, write enable) and the surrounding datapath steering for a RV32I subset. It sits between instruction memory and the datapath, latches each instruction, and sequences it through IF/ID/EX/MEM/WB. It supplies the register-file read addresses one cycle ahead of use, because register-file read data is registered on `clk`.

---
 rtl/multicycle_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle IF/ID/EX/MEM/WB control unit for an RV32I subset (R, I-ALU, LW, SW, BEQ).
// Define CTRL_ILLEGAL_TRAP_EN to halt on undefined opcodes; otherwise they retire as NOPs.
module multicycle_ctrl #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic                 zero,
    output logic [4:0]           read_reg1,
    output logic [4:0]           read_reg2,
    output logic [4:0]           write_reg,
    output logic                 reg_write,
    output logic [DATAWIDTH-1:0] imm,
    output logic                 alu_src,
    output logic [3:0]           alu_op,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 pc_load,
    output logic                 pc_sel,
    output logic                 illegal
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1000;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       pc_load;
        logic       br;
    } ctl_t;

    state_t      st, ns;
    logic [31:0] ir, nir;
    ctl_t        ctl;

    function automatic logic [3:0] alu_decode(input logic [31:0] i);
        logic [3:0] a;
        a = ALU_ADD;
        if (i[6:0] == OP_BEQ) begin
            a = ALU_SUB;
        end else if (i[6:0] == OP_R || i[6:0] == OP_I) begin
            case (i[14:12])
                3'b000:  a = (i[6:0] == OP_R && i[30]) ? ALU_SUB : ALU_ADD;
                3'b111:  a = ALU_AND;
                3'b110:  a = ALU_OR;
                3'b100:  a = ALU_XOR;
                3'b010:  a = ALU_SLT;
                default: a = ALU_ADD;
            endcase
        end
        return a;
    endfunction

    // Outputs are registered by decoding the state/IR the FSM is about to enter.
    function automatic ctl_t decode(input state_t s, input logic [31:0] i);
        ctl_t c;
        logic is_r, is_i, is_lw, is_sw, is_beq;
        is_r   = (i[6:0] == OP_R);
        is_i   = (i[6:0] == OP_I);
        is_lw  = (i[6:0] == OP_LW);
        is_sw  = (i[6:0] == OP_SW);
        is_beq = (i[6:0] == OP_BEQ);
        c = '0;
        case (s)
            S_EX: begin
                c.alu_op  = alu_decode(i);
                c.alu_src = is_i | is_lw | is_sw;
                c.pc_load = is_beq;
                c.br      = is_beq;
            end
            S_MEM: begin
                c.alu_op    = alu_decode(i);
                c.alu_src   = is_i | is_lw | is_sw;
                c.mem_read  = is_lw;
                c.mem_write = is_sw;
                c.pc_load   = is_sw;
            end
            S_WB: begin
                c.pc_load    = 1'b1;
                c.mem_to_reg = is_lw;
                // x0 is not protected in the register file, so never write it.
                c.reg_write  = (is_r | is_i | is_lw) && (i[11:7] != 5'd0);
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        ns  = st;
        nir = ir;
        case (st)
            S_IF: begin
                ns  = S_ID;
                nir = instr;
            end
            S_ID: begin
                case (ir[6:0])
                    OP_R, OP_I, OP_LW, OP_SW, OP_BEQ: ns = S_EX;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default: ns = S_HALT;
`else
                    default: ns = S_WB;
`endif
                endcase
            end
            S_EX: begin
                case (ir[6:0])
                    OP_R, OP_I:   ns = S_WB;
                    OP_LW, OP_SW: ns = S_MEM;
                    default:      ns = S_IF;
                endcase
            end
            S_MEM:   ns = (ir[6:0] == OP_LW) ? S_WB : S_IF;
            S_WB:    ns = S_IF;
            S_HALT:  ns = S_HALT;
            default: ns = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= S_IF;
            ir  <= '0;
            ctl <= '0;
        end else begin
            st  <= ns;
            ir  <= nir;
            ctl <= decode(ns, nir);
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else if (ns == S_HALT) illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        imm = '0;
        case (ir[6:0])
            OP_I, OP_LW: imm = {{(DATAWIDTH-12){ir[31]}}, ir[31:20]};
            OP_SW:       imm = {{(DATAWIDTH-12){ir[31]}}, ir[31:25], ir[11:7]};
            OP_BEQ:      imm = {{(DATAWIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default:     imm = '0;
        endcase
    end

    assign read_reg1  = ir[19:15];
    assign read_reg2  = ir[24:20];
    assign write_reg  = ir[11:7];
    assign reg_write  = ctl.reg_write;
    assign alu_src    = ctl.alu_src;
    assign alu_op     = ctl.alu_op;
    assign mem_read   = ctl.mem_read;
    assign mem_write  = ctl.mem_write;
    assign mem_to_reg = ctl.mem_to_reg;
    assign pc_load    = ctl.pc_load;
    // Branch outcome arrives from the ALU during EX, so it is gated in late.
    assign pc_sel     = ctl.br & zero;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expectations from a spec-level model,
// compared by a monitor at each pc_load.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic        reg_write, alu_src, mem_read, mem_write, mem_to_reg, pc_load, pc_sel, illegal;
    logic [31:0] imm;
    logic [3:0]  alu_op;

    multicycle_ctrl #(.DATAWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero),
        .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
        .reg_write(reg_write), .imm(imm), .alu_src(alu_src), .alu_op(alu_op),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .pc_load(pc_load), .pc_sel(pc_sel), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cycles;
        logic [4:0]  rr1, rr2, wr;
        logic [31:0] imm;
        logic [3:0]  aop;
        logic        asrc;
        int          nrw, nmw, nmr, nmtr;
        logic        psel;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference: what one instruction should look like end to end.
    function automatic exp_t model(input logic [31:0] i, input logic z);
        exp_t e;
        int   op, f3, v;
        op = int'(i[6:0]);
        f3 = int'(i[14:12]);
        e.rr1 = i[19:15]; e.rr2 = i[24:20]; e.wr = i[11:7];
        e.nrw = 0; e.nmw = 0; e.nmr = 0; e.nmtr = 0; e.psel = 1'b0; e.asrc = 1'b0;
        v = 0;
        if (op == 'h13 || op == 'h03) begin
            v = int'(i[31:20]);
            if (v >= 2048) v -= 4096;
        end else if (op == 'h23) begin
            v = int'(i[31:25]) * 32 + int'(i[11:7]);
            if (v >= 2048) v -= 4096;
        end else if (op == 'h63) begin
            v = int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            if (v >= 4096) v -= 8192;
        end
        e.imm = v;
        case (f3)
            0:       e.aop = (op == 'h33 && i[30]) ? 4'd6 : 4'd2;
            7:       e.aop = 4'd0;
            6:       e.aop = 4'd1;
            4:       e.aop = 4'd8;
            2:       e.aop = 4'd7;
            default: e.aop = 4'd2;
        endcase
        case (op)
            'h33: begin e.cycles = 4; e.nrw = (e.wr != 0); end
            'h13: begin e.cycles = 4; e.asrc = 1; e.nrw = (e.wr != 0); end
            'h03: begin e.cycles = 5; e.asrc = 1; e.aop = 4'd2; e.nmr = 1; e.nmtr = 1; e.nrw = (e.wr != 0); end
            'h23: begin e.cycles = 4; e.asrc = 1; e.aop = 4'd2; e.nmw = 1; end
            'h63: begin e.cycles = 3; e.aop = 4'd6; e.psel = z; end
            default: begin e.cycles = 3; e.aop = 4'd0; end // IF, ID, WB as a NOP
        endcase
        return e;
    endfunction

    // Monitor: accumulate one instruction's worth of outputs, compare at its pc_load.
    int          m_cyc = 0, m_nrw = 0, m_nmw = 0, m_nmr = 0, m_nmtr = 0;
    logic [4:0]  m_rr1, m_rr2, m_wr;
    logic [31:0] m_imm;
    logic [3:0]  m_aop;
    logic        m_asrc;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_cyc = 0; m_nrw = 0; m_nmw = 0; m_nmr = 0; m_nmtr = 0;
        end else begin
            m_cyc++;
            if (m_cyc == 2) begin m_rr1 = read_reg1; m_rr2 = read_reg2; m_wr = write_reg; m_imm = imm; end
            if (m_cyc == 3) begin m_aop = alu_op; m_asrc = alu_src; end
            m_nrw  += int'(reg_write);
            m_nmw  += int'(mem_write);
            m_nmr  += int'(mem_read);
            m_nmtr += int'(mem_to_reg);
            if (pc_load) begin
                if (q.size() == 0) begin
                    chk("unexpected_pc_load", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("cycles", m_cyc, e.cycles);
                    chk("read_reg1", m_rr1, e.rr1);
                    chk("read_reg2", m_rr2, e.rr2);
                    chk("write_reg", m_wr, e.wr);
                    chk("imm", m_imm, e.imm);
                    chk("alu_op", m_aop, e.aop);
                    chk("alu_src", m_asrc, e.asrc);
                    chk("reg_write_cnt", m_nrw, e.nrw);
                    chk("mem_write_cnt", m_nmw, e.nmw);
                    chk("mem_read_cnt", m_nmr, e.nmr);
                    chk("mem_to_reg_cnt", m_nmtr, e.nmtr);
                    chk("pc_sel", pc_sel, e.psel);
                end
                m_cyc = 0; m_nrw = 0; m_nmw = 0; m_nmr = 0; m_nmtr = 0;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [31:0] i, input logic z);
        bit seen = 0;
        q.push_back(model(i, z));
        instr = i;
        zero  = z;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            #1 if (pc_load) seen = 1;
        end
        if (!seen) chk("pc_load_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] i;
        int          k;
`ifdef CTRL_ILLEGAL_TRAP_EN
        k = $urandom_range(0, 4);
`else
        k = $urandom_range(0, 5);
`endif
        i = $urandom;
        case (k)
            0: begin i[6:0] = 7'h33; i[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00; end
            1: i[6:0] = 7'h13;
            2: i[6:0] = 7'h03;
            3: i[6:0] = 7'h23;
            4: i[6:0] = 7'h63;
            default: begin
                while (i[6:0] == 7'h33 || i[6:0] == 7'h13 || i[6:0] == 7'h03 ||
                       i[6:0] == 7'h23 || i[6:0] == 7'h63)
                    i[6:0] = 7'($urandom);
            end
        endcase
        return i;
    endfunction

    initial begin
        int bad;
        int npc;
        instr = 32'h002081B3;
        @(posedge clk);
        #1;
        chk("rst_strobes", {reg_write, mem_write, mem_read, mem_to_reg, pc_load, pc_sel, alu_src}, 32'd0);
        chk("rst_alu_op", alu_op, 32'd0);
        chk("rst_regs", {read_reg1, read_reg2, write_reg}, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_illegal", illegal, 32'd0);
        #1 rst_n = 1'b1;

        run_instr(32'h002081B3, 1'b0); // add x3,x1,x2
        run_instr(32'h40208133, 1'b0); // sub x2,x1,x2
        run_instr(32'h00A00013, 1'b0); // addi x0,x0,10
        run_instr(32'hFFC0A183, 1'b0); // lw x3,-4(x1)
        run_instr(32'hFE20AE23, 1'b0); // sw x2,-4(x1)
        run_instr(32'h00208463, 1'b1); // beq taken
        run_instr(32'h00208463, 1'b0); // beq not taken
`ifndef CTRL_ILLEGAL_TRAP_EN
        run_instr(32'hFFFFFFFF, 1'b0);
        chk("illegal_tied_low", illegal, 32'd0);
`endif

        // Abort an SW by asserting reset before it reaches MEM.
        instr = 32'hFE20AE23;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            bad += int'(mem_write) + int'(reg_write) + int'(pc_load);
        end
        chk("abort_sw_strobes", bad, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_instr(32'h002081B3, 1'b0);

        for (int n = 0; n < 60; n++) run_instr(gen_instr(), 1'($urandom));

`ifdef CTRL_ILLEGAL_TRAP_EN
        do_reset();
        instr = 32'hFFFFFFFF;
        npc = 0;
        repeat (12) begin
            @(negedge clk);
            npc += int'(pc_load) + int'(reg_write) + int'(mem_write);
        end
        chk("halt_no_strobes", npc, 32'd0);
        chk("halt_illegal_set", illegal, 32'd1);
        do_reset();
        chk("halt_illegal_cleared", illegal, 32'd0);
        run_instr(32'h002081B3, 1'b0);
`else
        npc = 0;
`endif

        chk("scoreboard_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
